// File: rtl/cmp_pipe.sv
// cmp_pipe: pipelined MSB-first magnitude comparator with valid/ready
// streaming, per-pair signed/unsigned mode and saturating event counters.
module cmp_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt
);

  localparam int unsigned S = WIDTH / CHUNK;

  localparam logic [1:0] ST_EQ = 2'd0;
  localparam logic [1:0] ST_GT = 2'd1;
  localparam logic [1:0] ST_LT = 2'd2;

  // Offset of stage j's leftover-operand field inside the packed remainder
  // vector; stage j keeps the CHUNK*(S-1-j) bits not compared yet.
  function automatic int unsigned rem_off(input int unsigned j);
    return CHUNK * (j * (S - 1) - (j * (j - 1)) / 2);
  endfunction

  // One decision step: only an undecided (EQ) pair looks at the chunk.
  function automatic logic [1:0] cmp_step(input logic [1:0]       st_in,
                                          input logic [CHUNK-1:0] ca,
                                          input logic [CHUNK-1:0] cb);
    logic [1:0] r;
    r = st_in;
    if (st_in == ST_EQ) begin
      if (ca > cb)      r = ST_GT;
      else if (ca < cb) r = ST_LT;
    end
    return r;
  endfunction

  logic             en;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic [1:0]       s0_st;
  logic [1:0]       last_st;
  logic             last_vld;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Offset-binary capture: flipping both MSBs makes unsigned compare signed.
  always_comb begin
    cap_a            = a;
    cap_b            = b;
    cap_a[WIDTH-1]   = a[WIDTH-1] ^ is_signed;
    cap_b[WIDTH-1]   = b[WIDTH-1] ^ is_signed;
  end

  assign s0_st = cmp_step(ST_EQ, cap_a[WIDTH-1 -: CHUNK], cap_b[WIDTH-1 -: CHUNK]);

  if (S == 1) begin : g_single
    assign last_st  = s0_st;
    assign last_vld = in_valid;
  end else begin : g_multi
    localparam int unsigned RT = CHUNK * S * (S - 1) / 2;

    logic [S-2:0]  vld;
    logic [1:0]    st     [S-1];
    logic [1:0]    nxt_st [S];
    logic [RT-1:0] rem_a;
    logic [RT-1:0] rem_b;
    logic [RT-1:0] rem_a_nxt;
    logic [RT-1:0] rem_b_nxt;

    assign nxt_st[0]                   = s0_st;
    assign rem_a_nxt[CHUNK*(S-1)-1:0]  = cap_a[WIDTH-CHUNK-1:0];
    assign rem_b_nxt[CHUNK*(S-1)-1:0]  = cap_b[WIDTH-CHUNK-1:0];

    // Stage k compares the top chunk of stage k-1's leftover and forwards the rest.
    for (genvar k = 1; k < S; k++) begin : g_stage
      localparam int unsigned K     = k;
      localparam int unsigned P_OFF = rem_off(K - 1);
      localparam int unsigned P_RW  = CHUNK * (S - K);

      assign nxt_st[k] = cmp_step(st[k-1],
                                  rem_a[P_OFF+P_RW-1 -: CHUNK],
                                  rem_b[P_OFF+P_RW-1 -: CHUNK]);

      if (K < S - 1) begin : g_fwd
        assign rem_a_nxt[rem_off(K) +: P_RW-CHUNK] = rem_a[P_OFF +: P_RW-CHUNK];
        assign rem_b_nxt[rem_off(K) +: P_RW-CHUNK] = rem_b[P_OFF +: P_RW-CHUNK];
      end
    end

    // Inner pipeline registers; every stage moves together when en is high.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld <= '0;
        for (int i = 0; i < S - 1; i++) st[i] <= ST_EQ;
        rem_a <= '0;
        rem_b <= '0;
      end else if (en) begin
        vld[0] <= in_valid;
        for (int i = 1; i < S - 1; i++) vld[i] <= vld[i-1];
        for (int i = 0; i < S - 1; i++) st[i] <= nxt_st[i];
        rem_a <= rem_a_nxt;
        rem_b <= rem_b_nxt;
      end
    end

    assign last_st  = nxt_st[S-1];
    assign last_vld = vld[S-2];
  end

  // Final stage: registered one-hot flags, all zero when no result is present.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      a_gt_b    <= 1'b0;
      a_eq_b    <= 1'b0;
      a_lt_b    <= 1'b0;
    end else if (en) begin
      out_valid <= last_vld;
      a_gt_b    <= last_vld && (last_st == ST_GT);
      a_eq_b    <= last_vld && (last_st == ST_EQ);
      a_lt_b    <= last_vld && (last_st == ST_LT);
    end
  end

  // Saturating delivery counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gt_cnt <= '0;
      eq_cnt <= '0;
      lt_cnt <= '0;
    end else if (clr_cnt) begin
      gt_cnt <= '0;
      eq_cnt <= '0;
      lt_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (a_gt_b && (gt_cnt != '1)) gt_cnt <= gt_cnt + CNT_W'(1);
      if (a_eq_b && (eq_cnt != '1)) eq_cnt <= eq_cnt + CNT_W'(1);
      if (a_lt_b && (lt_cnt != '1)) lt_cnt <= lt_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cmp_pipe.sv
// tb_cmp_pipe: directed and random checks of cmp_pipe at CHUNK 1/4/16 and CNT_W 4.
module tb_cmp_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        is_signed = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;

  // CHUNK=4 main instance
  logic ir4, ov4, gt4, eq4, lt4;
  logic [15:0] gc4, ec4, lc4;
  // CHUNK=4, CNT_W=4 saturation instance
  logic ir_s, ov_s, gt_s, eq_s, lt_s;
  logic [3:0] gc_s, ec_s, lc_s;
  // CHUNK=1 and CHUNK=16 instances
  logic ir1, ov1, gt1, eq1, lt1;
  logic [15:0] gc1, ec1, lc1;
  logic ir16, ov16, gt16, eq16, lt16;
  logic [15:0] gc16, ec16, lc16;

  always #5 clk = ~clk;

  cmp_pipe #(.WIDTH(16), .CHUNK(4), .CNT_W(16)) u_main (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4), .a(a), .b(b),
    .is_signed(is_signed), .out_valid(ov4), .out_ready(out_ready), .a_gt_b(gt4),
    .a_eq_b(eq4), .a_lt_b(lt4), .clr_cnt(clr_cnt), .gt_cnt(gc4), .eq_cnt(ec4), .lt_cnt(lc4));

  cmp_pipe #(.WIDTH(16), .CHUNK(4), .CNT_W(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_s), .a(a), .b(b),
    .is_signed(is_signed), .out_valid(ov_s), .out_ready(out_ready), .a_gt_b(gt_s),
    .a_eq_b(eq_s), .a_lt_b(lt_s), .clr_cnt(clr_cnt), .gt_cnt(gc_s), .eq_cnt(ec_s), .lt_cnt(lc_s));

  cmp_pipe #(.WIDTH(16), .CHUNK(1), .CNT_W(16)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1), .a(a), .b(b),
    .is_signed(is_signed), .out_valid(ov1), .out_ready(out_ready), .a_gt_b(gt1),
    .a_eq_b(eq1), .a_lt_b(lt1), .clr_cnt(clr_cnt), .gt_cnt(gc1), .eq_cnt(ec1), .lt_cnt(lc1));

  cmp_pipe #(.WIDTH(16), .CHUNK(16), .CNT_W(16)) u_c16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16), .a(a), .b(b),
    .is_signed(is_signed), .out_valid(ov16), .out_ready(out_ready), .a_gt_b(gt16),
    .a_eq_b(eq16), .a_lt_b(lt16), .clr_cnt(clr_cnt), .gt_cnt(gc16), .eq_cnt(ec16), .lt_cnt(lc16));

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_dlv    = 0;
  int m_gt = 0, m_eq = 0, m_lt = 0;
  logic [2:0] sb [$];
  logic [2:0] hist [1000];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference compare, returned as {gt, eq, lt}.
  function automatic logic [2:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
    logic gt, lt;
    if (s) begin
      gt = $signed(x) > $signed(y);
      lt = $signed(x) < $signed(y);
    end else begin
      gt = x > y;
      lt = x < y;
    end
    return {gt, !gt && !lt, lt};
  endfunction

  // One clock step with scoreboard bookkeeping for the main instance.
  task automatic tick();
    logic [2:0] e;
    #1;
    if (in_valid && ir4) begin
      sb.push_back(model(a, b, is_signed));
      n_acc++;
    end
    if (ov4 && out_ready) begin
      n_dlv++;
      if (sb.size() == 0) begin
        check("sb_extra_result", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("sb_flags", 32'({gt4, eq4, lt4}), 32'(e));
        if (e[2]) m_gt++;
        if (e[1]) m_eq++;
        if (e[0]) m_lt++;
      end
    end
    if (clr_cnt) begin
      m_gt = 0; m_eq = 0; m_lt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
    rst_n    = 1'b0;
    sb.delete();
    m_gt = 0; m_eq = 0; m_lt = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_gt"}, 32'(gc4), 32'(m_gt));
    check({tag, "_eq"}, 32'(ec4), 32'(m_eq));
    check({tag, "_lt"}, 32'(lc4), 32'(m_lt));
  endtask

  // Send one pair, measure accept-to-valid latency on the main instance.
  task automatic lat_test(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic s, input logic [2:0] exp_flags);
    int lat;
    a = x; b = y; is_signed = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!ov4 && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_flags"}, 32'({gt4, eq4, lt4}), 32'(exp_flags));
    tick();
  endtask

  task automatic sweep_chk(input string tag, input int n, input int lat_m1,
                           input logic [3:0] got);
    int idx;
    logic [3:0] exp;
    idx = n - lat_m1;
    exp = (idx >= 0 && idx < 1000) ? {1'b1, hist[idx]} : 4'b0000;
    check(tag, 32'(got), 32'(exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] bp_a [8];
    logic [15:0] bp_b [8];
    logic        bp_s [8];
    logic [3:0]  held;
    int base_d, base_a;

    // Reset values, sampled while reset is asserted
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 32'(ov4), 32'd0);
    check("rst_flags", 32'({gt4, eq4, lt4}), 32'd0);
    check("rst_cnts", 32'({gc4, ec4}) | 32'(lc4), 32'd0);
    check("rst_in_ready", 32'(ir4), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    // Unsigned/signed split and low-chunk decision
    lat_test("u_8000_7fff", 16'h8000, 16'h7FFF, 1'b0, 3'b100);
    lat_test("s_8000_7fff", 16'h8000, 16'h7FFF, 1'b1, 3'b001);

    // Back-to-back pairs, one result per cycle
    a = 16'h1234; b = 16'h1235; is_signed = 1'b0; in_valid = 1'b1;
    tick();
    a = 16'hFFFF; b = 16'hFFFF; is_signed = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("b2b_first", 32'({ov4, gt4, eq4, lt4}), 32'b1001);
    tick();
    check("b2b_second", 32'({ov4, gt4, eq4, lt4}), 32'b1010);
    tick();
    check("b2b_drained", 32'({ov4, gt4, eq4, lt4}), 32'b0000);
    check_cnts("cnt_directed");

    // Backpressure: 8 random pairs, out_ready low for 5 cycles mid-stream
    for (int i = 0; i < 8; i++) begin
      bp_a[i] = 16'($urandom);
      bp_b[i] = (i == 3) ? bp_a[i] : 16'($urandom);
      bp_s[i] = 1'($urandom);
    end
    base_d = n_dlv;
    base_a = n_acc;
    held   = '0;
    for (int cyc = 0; cyc < 60 && (n_dlv - base_d) < 8; cyc++) begin
      int s;
      s = n_acc - base_a;
      in_valid = (s < 8);
      if (s < 8) begin
        a = bp_a[s]; b = bp_b[s]; is_signed = bp_s[s];
      end
      out_ready = !(cyc >= 5 && cyc < 10);
      if (cyc >= 5 && cyc < 10) begin
        #1;
        check("bp_in_ready", 32'(ir4), 32'd0);
        if (cyc == 5) held = {ov4, gt4, eq4, lt4};
        else check("bp_hold", 32'({ov4, gt4, eq4, lt4}), 32'(held));
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_delivered", 32'(n_dlv - base_d), 32'd8);
    check("bp_sb_empty", 32'(sb.size()), 32'd0);
    check_cnts("cnt_bp");

    // Reset with 3 pairs in flight
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'(i * 16'h1111); b = 16'h2222; is_signed = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    m_gt = 0; m_eq = 0; m_lt = 0;
    check("mid_rst_out_valid", 32'(ov4), 32'd0);
    check_cnts("mid_rst_cnt");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_quiet", 32'(ov4), 32'd0);
    end
    lat_test("post_rst", 16'h00FF, 16'h0100, 1'b0, 3'b001);

    // Counter saturation on the CNT_W=4 instance, then clear on a delivery
    do_reset();
    a = 16'd2; b = 16'd1; is_signed = 1'b0; in_valid = 1'b1;
    repeat (20) tick();
    in_valid = 1'b0;
    repeat (6) tick();
    check("sat_gt", 32'(gc_s), 32'd15);
    check("sat_eq_lt", 32'({ec_s, lc_s}), 32'd0);
    check_cnts("cnt_20gt");
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("clr_deliver_valid", 32'(ov_s), 32'd1);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    check("clr_sat_cnts", 32'({gc_s, ec_s, lc_s}), 32'd0);
    check_cnts("clr_main");

    // CHUNK sweep: 1000 random pairs through S=16, 4 and 1
    do_reset();
    out_ready = 1'b1;
    for (int n = 0; n < 1016; n++) begin
      if (n < 1000) begin
        a = 16'($urandom);
        b = (n % 7 == 0) ? a : 16'($urandom);
        if (n % 11 == 0) b = a ^ 16'h0001;
        is_signed = 1'($urandom);
        hist[n] = model(a, b, is_signed);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      sweep_chk("sweep_c16", n, 0,  {ov16, gt16, eq16, lt16});
      sweep_chk("sweep_c4",  n, 3,  {ov4, gt4, eq4, lt4});
      sweep_chk("sweep_c1",  n, 15, {ov1, gt1, eq1, lt1});
    end
    check_cnts("cnt_sweep");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
